// File: rtl/intr_msg_queue.sv
// Interrupt request capture with per-vector mask/pending coalescing and a DEPTH-entry message FIFO.
// Capture-to-m_valid latency 1 cycle; m_ready low stalls the head, and a full FIFO diverts captures to pending.
module intr_msg_queue #(
    parameter int          PORTS         = 32,
    parameter int          DEPTH         = 8,
    parameter logic [31:0] MSG_DATA_BASE = 32'h0,
    localparam int         NW            = (PORTS > 1) ? $clog2(PORTS) : 1,
    localparam int         AW            = $clog2(DEPTH),
    localparam int         LW            = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             intr_vec_req,
    input  logic [NW-1:0]    intr_num,
    input  logic [PORTS-1:0] intr_mask,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [NW-1:0]    m_num,
    output logic [31:0]      m_data,
    output logic [PORTS-1:0] pending,
    output logic [LW-1:0]    fifo_level
);

    localparam logic [NW:0] PORTS_L = PORTS[NW:0];
    localparam logic [LW-1:0] DEPTH_L = DEPTH[LW-1:0];

    logic              req_q;
    logic              cap;
    logic              in_range;
    logic              full;
    logic              cap_push;
    logic              cap_hold;
    logic [PORTS-1:0]  rep_cand;
    logic              rep_any;
    logic [NW-1:0]     rep_idx;
    logic              rep_push;
    logic              push;
    logic [NW-1:0]     push_num;
    logic              pop;
    logic [PORTS-1:0]  pending_nxt;

    logic [NW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign cap      = intr_vec_req & ~req_q;
    assign in_range = ({1'b0, intr_num} < PORTS_L);
    assign full     = (fifo_level == DEPTH_L);

    // Masked or full captures land in pending; an already-pending vector coalesces.
    assign cap_hold = cap & in_range & (intr_mask[intr_num] | full);
    assign cap_push = cap & in_range & ~intr_mask[intr_num] & ~full & ~pending[intr_num];

    assign rep_cand = pending & ~intr_mask;

    always_comb begin
        rep_any = 1'b0;
        rep_idx = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (rep_cand[i]) begin
                rep_any = 1'b1;
                rep_idx = NW'(i);
            end
        end
    end

    assign rep_push = rep_any & ~cap_push & ~full;
    assign push     = cap_push | rep_push;
    assign push_num = cap_push ? intr_num : rep_idx;
    assign pop      = m_valid & m_ready;

    always_comb begin
        pending_nxt = pending;
        if (rep_push) pending_nxt[rep_idx] = 1'b0;
        if (cap_hold) pending_nxt[intr_num] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= 1'b0;
            pending    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            req_q   <= intr_vec_req;
            pending <= pending_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_level <= fifo_level + LW'(1);
            else if (pop && !push) fifo_level <= fifo_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_num;
    end

    assign m_valid = (fifo_level != '0);
    assign m_num   = m_valid ? mem[rd_ptr] : '0;
    assign m_data  = MSG_DATA_BASE + 32'(m_num);

endmodule
